// File: rtl/fork_join_ctrl.sv
// Fork/join sequencer: launches up to SUBCORE_NUM sub cores in index order,
// then stalls the main core on Join until every launched core has finished.
module fork_join_ctrl #(
  parameter int SUBCORE_NUM = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   fork_req,
  input  logic [31:0]            fork_pc,
  input  logic [31:0]            fork_count,
  input  logic                   join_req,
  input  logic [SUBCORE_NUM-1:0] sub_ready,
  input  logic [SUBCORE_NUM-1:0] sub_done,
  output logic [SUBCORE_NUM-1:0] sub_start,
  output logic [31:0]            sub_pc,
  output logic [31:0]            sub_arg,
  output logic                   interlock,
  output logic [SUBCORE_NUM-1:0] busy,
  output logic                   join_done,
  output logic                   err
);

  // state  | meaning
  // IDLE   | nothing outstanding; accepts fork and join
  // LAUNCH | starting sub cores one per handshake; main core stalled
  // RUN    | launched cores running; main core free
  // JOIN   | waiting for launched cores to finish; main core stalled
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_JOIN   = 2'd3;

  localparam int IW = (SUBCORE_NUM > 1) ? $clog2(SUBCORE_NUM) : 1;
  localparam int CW = $clog2(SUBCORE_NUM + 1);

  logic [1:0]             state, state_nxt;
  logic [IW-1:0]          idx, idx_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [31:0]            pc_q, pc_nxt;
  logic [SUBCORE_NUM-1:0] busy_nxt;
  logic [SUBCORE_NUM-1:0] done_q, done_nxt, done_set;
  logic                   err_nxt;
  logic                   join_done_nxt;
  logic                   join_eff;
  logic                   hs;
  logic                   last;
  logic                   all_done;

  // A simultaneous fork wins; the join is dropped (and flagged below).
  assign join_eff = join_req & ~fork_req;
  assign done_set = sub_done & busy;
  assign all_done = ((busy & ~(done_q | done_set)) == '0);
  assign hs       = (state == ST_LAUNCH) && sub_ready[idx];
  assign last     = ((32'(idx) + 32'd1) == 32'(cnt));

  assign interlock = (state == ST_LAUNCH) || (state == ST_JOIN);
  assign sub_pc    = pc_q;
  assign sub_arg   = 32'(idx);

  always_comb begin
    for (int i = 0; i < SUBCORE_NUM; i++) begin
      sub_start[i] = (state == ST_LAUNCH) && (idx == IW'(i));
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    cnt_nxt       = cnt;
    pc_nxt        = pc_q;
    busy_nxt      = busy;
    done_nxt      = done_q | done_set;
    err_nxt       = err;
    join_done_nxt = 1'b0;

    if (fork_req && join_req) begin
      err_nxt = 1'b1;
    end
    if (fork_req && (state != ST_IDLE)) begin
      err_nxt = 1'b1;
    end
    if (join_eff && ((state == ST_LAUNCH) || (state == ST_JOIN))) begin
      err_nxt = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (fork_req && (fork_count != 32'd0)) begin
          pc_nxt    = fork_pc;
          cnt_nxt   = (fork_count >= 32'(SUBCORE_NUM)) ? CW'(SUBCORE_NUM)
                                                       : fork_count[CW-1:0];
          idx_nxt   = '0;
          state_nxt = ST_LAUNCH;
        end else if (join_eff) begin
          join_done_nxt = 1'b1;
        end
      end
      ST_LAUNCH: begin
        if (hs) begin
          busy_nxt[idx] = 1'b1;
          done_nxt[idx] = 1'b0;
          if (last) begin
            state_nxt = ST_RUN;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (join_eff) begin
          if (all_done) begin
            state_nxt     = ST_IDLE;
            busy_nxt      = '0;
            done_nxt      = '0;
            join_done_nxt = 1'b1;
          end else begin
            state_nxt = ST_JOIN;
          end
        end
      end
      default: begin
        if (all_done) begin
          state_nxt     = ST_IDLE;
          busy_nxt      = '0;
          done_nxt      = '0;
          join_done_nxt = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      idx       <= '0;
      cnt       <= '0;
      pc_q      <= '0;
      busy      <= '0;
      done_q    <= '0;
      err       <= 1'b0;
      join_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      pc_q      <= pc_nxt;
      busy      <= busy_nxt;
      done_q    <= done_nxt;
      err       <= err_nxt;
      join_done <= join_done_nxt;
    end
  end

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Scoreboard bench for fork_join_ctrl: stimulus pushes expected launches and
// join completions; a negedge monitor pops and compares them.
module tb_fork_join_ctrl;
  localparam int N = 4;

  logic          clk;
  logic          rstn;
  logic          fork_req;
  logic [31:0]   fork_pc;
  logic [31:0]   fork_count;
  logic          join_req;
  logic [N-1:0]  sub_ready;
  logic [N-1:0]  sub_done;
  logic [N-1:0]  sub_start;
  logic [31:0]   sub_pc;
  logic [31:0]   sub_arg;
  logic          interlock;
  logic [N-1:0]  busy;
  logic          join_done;
  logic          err;

  fork_join_ctrl #(.SUBCORE_NUM(N)) dut (
    .clk(clk), .rstn(rstn), .fork_req(fork_req), .fork_pc(fork_pc),
    .fork_count(fork_count), .join_req(join_req), .sub_ready(sub_ready),
    .sub_done(sub_done), .sub_start(sub_start), .sub_pc(sub_pc),
    .sub_arg(sub_arg), .interlock(interlock), .busy(busy),
    .join_done(join_done), .err(err)
  );

  typedef struct {
    logic [N-1:0] start;
    logic [31:0]  pc;
    logic [31:0]  arg;
    int           cyc;
  } launch_t;

  launch_t      launch_q[$];
  int           join_q[$];
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_fail = 0;
  logic [N-1:0] exp_busy = '0;
  bit           exp_err = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (sub_start != '0) begin
        if (launch_q.size() == 0) begin
          chk("unexpected_start", 32'(sub_start), 32'h0);
        end else begin
          chk("start_vec", 32'(sub_start), 32'(launch_q[0].start));
          chk("start_pc", sub_pc, launch_q[0].pc);
          chk("start_arg", sub_arg, launch_q[0].arg);
          chk("start_lock", 32'(interlock), 32'h1);
          if ((sub_start & sub_ready) != '0) begin
            chk("start_cycle", 32'(cyc), 32'(launch_q[0].cyc));
            void'(launch_q.pop_front());
          end
        end
      end
      if (join_done === 1'b1) begin
        if (join_q.size() == 0) begin
          chk("unexpected_join_done", 32'h1, 32'h0);
        end else begin
          chk("join_done_cycle", 32'(cyc), 32'(join_q[0]));
          void'(join_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    rstn = 1'b0;
    launch_q.delete();
    join_q.delete();
    fork_req = 1'b0; join_req = 1'b0; sub_done = '0; sub_ready = '1;
    tick();
    rstn = 1'b1;
    exp_err = 1'b0;
    exp_busy = '0;
    @(negedge clk);
    chk("rst_interlock", 32'(interlock), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_join_done", 32'(join_done), 32'h0);
    chk("rst_sub_start", 32'(sub_start), 32'h0);
    chk("rst_sub_pc", sub_pc, 32'h0);
    chk("rst_sub_arg", sub_arg, 32'h0);
    tick();
  endtask

  // inject: 0 none, 1 fork during launch, 2 join during launch
  task automatic do_fork(input logic [31:0] pc, input logic [31:0] count,
                         input int stalls[N], input int inject, input bit with_join);
    int c, k, h, nb;
    int b[N];
    launch_t e;
    c = cyc;
    k = (count > 32'(N)) ? N : int'(count);
    fork_pc = pc; fork_count = count; fork_req = 1'b1;
    if (with_join) begin
      join_req = 1'b1;
      exp_err = 1'b1;
    end
    nb = c + 1;
    for (int i = 0; i < k; i++) begin
      b[i] = nb;
      e.start = '0;
      e.start[i] = 1'b1;
      e.pc = pc;
      e.arg = 32'(i);
      e.cyc = nb + stalls[i];
      launch_q.push_back(e);
      nb = nb + stalls[i] + 1;
    end
    h = nb - 1;
    tick();
    fork_req = 1'b0; join_req = 1'b0;
    while (cyc <= h) begin
      sub_ready = '1;
      for (int i = 0; i < k; i++) begin
        if (cyc >= b[i] && cyc < b[i] + stalls[i]) sub_ready[i] = 1'b0;
      end
      if (inject == 1 && cyc == c + 1) begin
        fork_req = 1'b1; fork_pc = ~pc; fork_count = 32'd1; exp_err = 1'b1;
      end
      if (inject == 2 && cyc == c + 1) begin
        join_req = 1'b1; exp_err = 1'b1;
      end
      tick();
      fork_req = 1'b0; join_req = 1'b0;
    end
    sub_ready = '1;
    for (int i = 0; i < k; i++) exp_busy[i] = 1'b1;
    @(negedge clk);
    chk("fork_busy", 32'(busy), 32'(exp_busy));
    chk("fork_interlock", 32'(interlock), 32'h0);
    chk("fork_err", 32'(err), 32'(exp_err));
    chk("fork_pending", 32'(launch_q.size()), 32'h0);
    tick();
  endtask

  task automatic do_join(input int jd, input int d_off[N]);
    int r, tj, e_cyc, t;
    r = cyc;
    tj = r + jd;
    e_cyc = tj;
    for (int i = 0; i < N; i++) begin
      if (exp_busy[i] && (r + d_off[i]) > e_cyc) e_cyc = r + d_off[i];
    end
    e_cyc = e_cyc + 1;
    join_q.push_back(e_cyc);
    while (cyc <= e_cyc) begin
      sub_done = N'($urandom) & ~exp_busy;
      for (int i = 0; i < N; i++) begin
        if (exp_busy[i] && (r + d_off[i]) == cyc) sub_done[i] = 1'b1;
      end
      join_req = (cyc == tj);
      @(negedge clk);
      t = cyc;
      if (t == e_cyc) begin
        chk("join_end_interlock", 32'(interlock), 32'h0);
        chk("join_end_busy", 32'(busy), 32'h0);
      end else begin
        chk("join_interlock", 32'(interlock), (t > tj) ? 32'h1 : 32'h0);
        chk("join_busy", 32'(busy), 32'(exp_busy));
      end
      tick();
      sub_done = '0; join_req = 1'b0;
    end
    exp_busy = '0;
    @(negedge clk);
    chk("join_err", 32'(err), 32'(exp_err));
    chk("join_pending", 32'(join_q.size()), 32'h0);
    tick();
  endtask

  task automatic do_idle_join();
    join_q.push_back(cyc + 1);
    join_req = 1'b1;
    tick();
    join_req = 1'b0;
    @(negedge clk);
    chk("idle_join_interlock", 32'(interlock), 32'h0);
    tick();
    chk("idle_join_pending", 32'(join_q.size()), 32'h0);
  endtask

  task automatic do_run_fork();
    fork_req = 1'b1; fork_pc = 32'hDEAD; fork_count = 32'd2;
    exp_err = 1'b1;
    tick();
    fork_req = 1'b0;
    @(negedge clk);
    chk("run_fork_interlock", 32'(interlock), 32'h0);
    chk("run_fork_err", 32'(err), 32'h1);
    tick();
  endtask

  initial begin
    int st[N];
    int d[N];
    int zero[N];
    launch_t e;
    logic [31:0] cnt, pc;
    int inj;
    rstn = 1'b0; fork_req = 1'b0; fork_pc = '0; fork_count = '0;
    join_req = 1'b0; sub_ready = '1; sub_done = '0;
    for (int i = 0; i < N; i++) zero[i] = 0;
    tick();
    do_reset();

    // three back-to-back launches, then join with dones already in
    do_fork(32'h100, 32'd3, zero, 0, 1'b0);
    d = '{0, 1, 2, 0};
    do_join(4, d);

    // cores 0/1: join first, dones at +2 and +6
    do_fork(32'h200, 32'd2, zero, 0, 1'b0);
    d = '{2, 6, 0, 0};
    do_join(0, d);

    // both cores finished before the join
    do_fork(32'h300, 32'd2, zero, 0, 1'b0);
    d = '{0, 0, 0, 0};
    do_join(3, d);

    // count above N saturates
    do_fork(32'h400, 32'd9, zero, 0, 1'b0);
    chk("sat_busy_recorded", 32'(exp_busy), 32'hF);
    d = '{1, 3, 5, 2};
    do_join(2, d);

    // core 1 ready held low five cycles
    st = '{0, 5, 0, 0};
    do_fork(32'h500, 32'd2, st, 0, 1'b0);
    d = '{1, 1, 0, 0};
    do_join(0, d);

    // fork during launch flags err, sequence unchanged; reset clears it
    st = '{1, 0, 0, 0};
    do_fork(32'h600, 32'd3, st, 1, 1'b0);
    do_reset();

    // zero-count fork is a no-op; join from idle
    do_fork(32'h700, 32'd0, zero, 0, 1'b0);
    chk("zero_fork_err", 32'(err), 32'h0);
    do_idle_join();

    // fork and join together: fork wins, err set
    do_fork(32'h800, 32'd1, zero, 0, 1'b1);
    d = '{0, 0, 0, 0};
    do_join(1, d);
    do_reset();

    // reset while stalled in launch abandons it
    fork_pc = 32'hABC0; fork_count = 32'd4; fork_req = 1'b1; sub_ready = '0;
    e.start = 4'b0001; e.pc = 32'hABC0; e.arg = 32'd0; e.cyc = -1;
    launch_q.push_back(e);
    tick();
    fork_req = 1'b0;
    tick();
    tick();
    do_reset();
    repeat (3) tick();

    for (int it = 0; it < 25; it++) begin
      cnt = 32'($urandom_range(0, 6));
      pc = $urandom;
      for (int i = 0; i < N; i++) st[i] = $urandom_range(0, 3);
      inj = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
      do_fork(pc, cnt, st, inj, 1'b0);
      if (exp_busy != '0) begin
        if ($urandom_range(0, 5) == 0) do_run_fork();
        for (int i = 0; i < N; i++) d[i] = $urandom_range(0, 8);
        do_join($urandom_range(0, 8), d);
      end else begin
        do_idle_join();
      end
      if (exp_err && $urandom_range(0, 2) == 0) do_reset();
    end

    repeat (4) tick();
    chk("final_launch_q", 32'(launch_q.size()), 32'h0);
    chk("final_join_q", 32'(join_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
